// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one main-memory interface between the I-cache and D-cache
// refill/writeback paths. Requests are accepted one at a time. The
// sequencer then runs the command phase, followed by either the write-data
// phase or the read-response phase, and routes read beats back to the
// owning cache. When both caches request in the same cycle, the one not
// granted last time wins.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   {ic,dc}_req_valid/ready/rw/addr block request handshake (rw=1 write)
//   {ic,dc}_wdata_valid/ready/wdata/wmask  write beats from the caches
//   {ic,dc}_resp_valid/data         read beats to the caches
//   mem_req_valid/ready/rw/addr     command toward memory
//   mem_req_data_valid/ready/bits/mask  write beats toward memory
//   mem_resp_valid/data             read beats from memory
//   busy                            high whenever a transfer is in progress
module mem_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int BEATS      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ic_req_valid,
    output logic                    ic_req_ready,
    input  logic                    ic_req_rw,
    input  logic [ADDR_WIDTH-1:0]   ic_req_addr,
    input  logic                    ic_wdata_valid,
    output logic                    ic_wdata_ready,
    input  logic [DATA_WIDTH-1:0]   ic_wdata,
    input  logic [DATA_WIDTH/8-1:0] ic_wmask,
    output logic                    ic_resp_valid,
    output logic [DATA_WIDTH-1:0]   ic_resp_data,
    input  logic                    dc_req_valid,
    output logic                    dc_req_ready,
    input  logic                    dc_req_rw,
    input  logic [ADDR_WIDTH-1:0]   dc_req_addr,
    input  logic                    dc_wdata_valid,
    output logic                    dc_wdata_ready,
    input  logic [DATA_WIDTH-1:0]   dc_wdata,
    input  logic [DATA_WIDTH/8-1:0] dc_wmask,
    output logic                    dc_resp_valid,
    output logic [DATA_WIDTH-1:0]   dc_resp_data,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_rw,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic                    mem_req_data_valid,
    input  logic                    mem_req_data_ready,
    output logic [DATA_WIDTH-1:0]   mem_req_data_bits,
    output logic [DATA_WIDTH/8-1:0] mem_req_data_mask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data,
    output logic                    busy
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;
    typedef enum logic {SRC_IC, SRC_DC} src_t;

    state_t           state;
    src_t             owner;
    src_t             last_grant;
    logic [CNT_W-1:0] cnt;

    logic grant_ic;
    logic grant_dc;
    logic last_beat;
    logic wr_fire;
    logic rd_fire;

    // On a tie, the requester that did not win last time is granted.
    always_comb begin
        grant_ic = ic_req_valid && (!dc_req_valid || last_grant == SRC_DC);
        grant_dc = dc_req_valid && (!ic_req_valid || last_grant == SRC_IC);
    end

    always_comb begin
        ic_req_ready       = !reset && state == IDLE && grant_ic;
        dc_req_ready       = !reset && state == IDLE && grant_dc;

        mem_req_valid      = state == CMD;
        mem_req_data_valid = state == WDATA &&
                             (owner == SRC_DC ? dc_wdata_valid : ic_wdata_valid);
        mem_req_data_bits  = (owner == SRC_DC) ? dc_wdata : ic_wdata;
        mem_req_data_mask  = (owner == SRC_DC) ? dc_wmask : ic_wmask;

        ic_wdata_ready     = state == WDATA && owner == SRC_IC && mem_req_data_ready;
        dc_wdata_ready     = state == WDATA && owner == SRC_DC && mem_req_data_ready;

        // A memory beat reaches only the owner, and only during RDATA.
        ic_resp_valid      = state == RDATA && owner == SRC_IC && mem_resp_valid;
        dc_resp_valid      = state == RDATA && owner == SRC_DC && mem_resp_valid;
        ic_resp_data       = mem_resp_data;
        dc_resp_data       = mem_resp_data;

        busy               = state != IDLE;

        last_beat          = cnt == CNT_W'(BEATS - 1);
        wr_fire            = mem_req_data_valid && mem_req_data_ready;
        rd_fire            = state == RDATA && mem_resp_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= SRC_IC;
            last_grant   <= SRC_IC;
            cnt          <= '0;
            mem_req_rw   <= 1'b0;
            mem_req_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dc) begin
                        owner        <= SRC_DC;
                        last_grant   <= SRC_DC;
                        mem_req_rw   <= dc_req_rw;
                        mem_req_addr <= dc_req_addr;
                        state        <= CMD;
                    end else if (grant_ic) begin
                        owner        <= SRC_IC;
                        last_grant   <= SRC_IC;
                        mem_req_rw   <= ic_req_rw;
                        mem_req_addr <= ic_req_addr;
                        state        <= CMD;
                    end
                end
                CMD: begin
                    if (mem_req_ready) begin
                        cnt   <= '0;
                        state <= mem_req_rw ? WDATA : RDATA;
                    end
                end
                WDATA: begin
                    if (wr_fire) begin
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                        if (last_beat) state <= IDLE;
                    end
                end
                RDATA: begin
                    if (rd_fire) begin
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                        if (last_beat) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int AW    = 28;
    localparam int DW    = 128;
    localparam int MW    = DW / 8;
    localparam int BEATS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req_valid, ic_req_ready, ic_req_rw;
    logic [AW-1:0] ic_req_addr;
    logic          ic_wdata_valid, ic_wdata_ready;
    logic [DW-1:0] ic_wdata;
    logic [MW-1:0] ic_wmask;
    logic          ic_resp_valid;
    logic [DW-1:0] ic_resp_data;
    logic          dc_req_valid, dc_req_ready, dc_req_rw;
    logic [AW-1:0] dc_req_addr;
    logic          dc_wdata_valid, dc_wdata_ready;
    logic [DW-1:0] dc_wdata;
    logic [MW-1:0] dc_wmask;
    logic          dc_resp_valid;
    logic [DW-1:0] dc_resp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_data_valid, mem_req_data_ready;
    logic [DW-1:0] mem_req_data_bits;
    logic [MW-1:0] mem_req_data_mask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          busy;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
        .ic_req_rw(ic_req_rw), .ic_req_addr(ic_req_addr),
        .ic_wdata_valid(ic_wdata_valid), .ic_wdata_ready(ic_wdata_ready),
        .ic_wdata(ic_wdata), .ic_wmask(ic_wmask),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
        .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
        .dc_wdata(dc_wdata), .dc_wmask(dc_wmask),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy)
    );

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ic_req_valid = 0; ic_req_rw = 0; ic_req_addr = '0;
        dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0;
        ic_wdata_valid = 0; ic_wdata = '0; ic_wmask = '0;
        dc_wdata_valid = 0; dc_wdata = '0; dc_wmask = '0;
        mem_req_ready = 0; mem_req_data_ready = 0;
        mem_resp_valid = 0; mem_resp_data = '0;
    endtask

    task automatic test_reset();
        reset = 1;
        drive_idle();
        ic_req_valid = 1; dc_req_valid = 1; mem_resp_valid = 1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk_cnt++;
        if ({ic_req_ready, dc_req_ready, busy, mem_req_valid, mem_req_data_valid,
             ic_resp_valid, dc_resp_valid, ic_wdata_ready, dc_wdata_ready} !== 9'b0)
            $display("FAIL reset_flags: got %b want 000000000",
                     {ic_req_ready, dc_req_ready, busy, mem_req_valid, mem_req_data_valid,
                      ic_resp_valid, dc_resp_valid, ic_wdata_ready, dc_wdata_ready});
        else pass_cnt++;
        chk_cnt++;
        if ({mem_req_rw, mem_req_addr} !== '0)
            $display("FAIL reset_cmd: got rw=%0b addr=%h want 0/0", mem_req_rw, mem_req_addr);
        else pass_cnt++;
        next_cycle();
        reset = 0;
        drive_idle();
    endtask

    task automatic test_single_read();
        logic [DW-1:0] e;
        dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h0000123; mem_req_ready = 1;
        @(negedge clk);
        chk_cnt++;
        if ({ic_req_ready, dc_req_ready} !== 2'b01)
            $display("FAIL sr_grant: got ic/dc ready=%b want 01", {ic_req_ready, dc_req_ready});
        else pass_cnt++;
        next_cycle();
        dc_req_valid = 0;
        @(negedge clk);
        chk_cnt++;
        if ({mem_req_valid, mem_req_rw, mem_req_addr} !== {1'b1, 1'b0, 28'h0000123})
            $display("FAIL sr_cmd: got v=%0b rw=%0b addr=%h want 1/0/0000123",
                     mem_req_valid, mem_req_rw, mem_req_addr);
        else pass_cnt++;
        for (int i = 0; i < BEATS; i++) begin
            next_cycle();
            e = DW'(8'hA0 + i);
            mem_resp_valid = 1; mem_resp_data = e;
            @(negedge clk);
            chk_cnt++;
            if ({ic_resp_valid, dc_resp_valid, dc_resp_data} !== {1'b0, 1'b1, e})
                $display("FAIL sr_beat%0d: got ic_v=%0b dc_v=%0b data=%h want 0/1/%h",
                         i, ic_resp_valid, dc_resp_valid, dc_resp_data, e);
            else pass_cnt++;
        end
        next_cycle();
        mem_resp_valid = 0;
        @(negedge clk);
        chk_cnt++;
        if ({busy, ic_resp_valid, dc_resp_valid} !== 3'b000)
            $display("FAIL sr_done: got busy/icv/dcv=%b want 000", {busy, ic_resp_valid, dc_resp_valid});
        else pass_cnt++;
        next_cycle();
        drive_idle();
    endtask

    task automatic test_round_robin();
        bit exp_dc;
        reset = 1;
        next_cycle();
        reset = 0;
        ic_req_valid = 1; ic_req_rw = 0; ic_req_addr = 28'h0000AAA;
        dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h0000BBB;
        exp_dc = 1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk_cnt++;
            if ({ic_req_ready, dc_req_ready} !== (exp_dc ? 2'b01 : 2'b10))
                $display("FAIL rr_grant%0d: got ic/dc ready=%b want %b", t,
                         {ic_req_ready, dc_req_ready}, exp_dc ? 2'b01 : 2'b10);
            else pass_cnt++;
            next_cycle();
            mem_req_ready = 1;
            @(negedge clk);
            chk_cnt++;
            if (mem_req_addr !== (exp_dc ? 28'h0000BBB : 28'h0000AAA))
                $display("FAIL rr_addr%0d: got %h want %h", t, mem_req_addr,
                         exp_dc ? 28'h0000BBB : 28'h0000AAA);
            else pass_cnt++;
            for (int b = 0; b < BEATS; b++) begin
                next_cycle();
                mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = rnd_data();
                @(negedge clk);
                chk_cnt++;
                if ({ic_resp_valid, dc_resp_valid} !== (exp_dc ? 2'b01 : 2'b10))
                    $display("FAIL rr_resp%0d_%0d: got ic/dc valid=%b want %b", t, b,
                             {ic_resp_valid, dc_resp_valid}, exp_dc ? 2'b01 : 2'b10);
                else pass_cnt++;
            end
            next_cycle();
            mem_resp_valid = 0;
            exp_dc = !exp_dc;
        end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_write_stall();
        logic [DW-1:0] wd [BEATS];
        logic [MW-1:0] wm [BEATS];
        int  k, cyc;
        bit  rdy;
        for (int i = 0; i < BEATS; i++) begin
            wd[i] = rnd_data();
            wm[i] = MW'($urandom);
        end
        dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h0000040;
        @(negedge clk);
        chk_cnt++;
        if (dc_req_ready !== 1'b1) $display("FAIL wr_grant: got dc_req_ready=%0b want 1", dc_req_ready);
        else pass_cnt++;
        next_cycle();
        dc_req_valid = 0; mem_req_ready = 1;
        @(negedge clk);
        chk_cnt++;
        if ({mem_req_valid, mem_req_rw, mem_req_addr} !== {1'b1, 1'b1, 28'h0000040})
            $display("FAIL wr_cmd: got v=%0b rw=%0b addr=%h want 1/1/0000040",
                     mem_req_valid, mem_req_rw, mem_req_addr);
        else pass_cnt++;
        next_cycle();
        mem_req_ready = 0;
        k = 0; cyc = 0;
        while (k < BEATS && cyc < 20) begin
            rdy = (cyc % 2 == 0);
            dc_wdata_valid = 1; dc_wdata = wd[k]; dc_wmask = wm[k];
            ic_wdata_valid = 1; ic_wdata = ~wd[k]; ic_wmask = ~wm[k];
            mem_req_data_ready = rdy;
            mem_resp_valid = 1; mem_resp_data = rnd_data();
            @(negedge clk);
            chk_cnt++;
            if ({mem_req_data_valid, mem_req_data_bits, mem_req_data_mask} !== {1'b1, wd[k], wm[k]})
                $display("FAIL wr_beat%0d: got v=%0b bits=%h mask=%h want 1/%h/%h", k,
                         mem_req_data_valid, mem_req_data_bits, mem_req_data_mask, wd[k], wm[k]);
            else pass_cnt++;
            chk_cnt++;
            if ({ic_wdata_ready, dc_wdata_ready, ic_resp_valid, dc_resp_valid, busy} !== {1'b0, rdy, 3'b001})
                $display("FAIL wr_ctl%0d: got icwr/dcwr/icv/dcv/busy=%b want %b", cyc,
                         {ic_wdata_ready, dc_wdata_ready, ic_resp_valid, dc_resp_valid, busy},
                         {1'b0, rdy, 3'b001});
            else pass_cnt++;
            if (rdy) k++;
            cyc++;
            next_cycle();
        end
        drive_idle();
        @(negedge clk);
        chk_cnt++;
        if (k !== BEATS || busy !== 1'b0 || mem_req_data_valid !== 1'b0)
            $display("FAIL wr_done: got beats=%0d busy=%0b dv=%0b want %0d/0/0",
                     k, busy, mem_req_data_valid, BEATS);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_cmd_backpressure();
        logic [AW-1:0] a;
        a = AW'($urandom);
        ic_req_valid = 1; ic_req_rw = 0; ic_req_addr = a;
        @(negedge clk);
        chk_cnt++;
        if ({ic_req_ready, dc_req_ready} !== 2'b10)
            $display("FAIL bp_grant: got ic/dc ready=%b want 10", {ic_req_ready, dc_req_ready});
        else pass_cnt++;
        next_cycle();
        ic_req_valid = 0; ic_req_addr = '0;
        for (int c = 0; c < 10; c++) begin
            if (c >= 3) begin
                dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = ~a;
            end
            @(negedge clk);
            chk_cnt++;
            if ({mem_req_valid, mem_req_rw, mem_req_addr, dc_req_ready} !== {1'b1, 1'b0, a, 1'b0})
                $display("FAIL bp_hold%0d: got v=%0b rw=%0b addr=%h dc_ready=%0b want 1/0/%h/0", c,
                         mem_req_valid, mem_req_rw, mem_req_addr, dc_req_ready, a);
            else pass_cnt++;
            next_cycle();
        end
        dc_req_valid = 0;
        mem_req_ready = 1;
        next_cycle();
        mem_req_ready = 0;
        for (int b = 0; b < BEATS; b++) begin
            mem_resp_valid = 1; mem_resp_data = rnd_data();
            @(negedge clk);
            chk_cnt++;
            if ({ic_resp_valid, dc_resp_valid, ic_resp_data} !== {2'b10, mem_resp_data})
                $display("FAIL bp_beat%0d: got ic/dc valid=%b data=%h want 10/%h", b,
                         {ic_resp_valid, dc_resp_valid}, ic_resp_data, mem_resp_data);
            else pass_cnt++;
            next_cycle();
        end
        drive_idle();
        @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL bp_done: got busy=%0b want 0", busy);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_stray_resp();
        // Stray beats in IDLE, in the grant cycle and throughout CMD.
        for (int c = 0; c < 6; c++) begin
            mem_resp_valid = 1; mem_resp_data = rnd_data();
            if (c == 2) begin
                ic_req_valid = 1; ic_req_rw = 0; ic_req_addr = 28'h0000777;
            end else begin
                ic_req_valid = 0;
            end
            mem_req_ready = (c == 5);
            @(negedge clk);
            chk_cnt++;
            if ({ic_resp_valid, dc_resp_valid, busy} !== {2'b00, c > 2})
                $display("FAIL stray%0d: got icv/dcv/busy=%b want %b", c,
                         {ic_resp_valid, dc_resp_valid, busy}, {2'b00, c > 2});
            else pass_cnt++;
            next_cycle();
        end
        drive_idle();
        // A full block must still take exactly BEATS beats; a 5th beat is stray.
        for (int b = 0; b <= BEATS; b++) begin
            mem_resp_valid = 1; mem_resp_data = rnd_data();
            @(negedge clk);
            chk_cnt++;
            if ({ic_resp_valid, dc_resp_valid, busy} !== ((b < BEATS) ? 3'b101 : 3'b000))
                $display("FAIL stray_read%0d: got icv/dcv/busy=%b want %b", b,
                         {ic_resp_valid, dc_resp_valid, busy}, (b < BEATS) ? 3'b101 : 3'b000);
            else pass_cnt++;
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_read();
        dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h0000200;
        mem_req_ready = 1;
        next_cycle();
        dc_req_valid = 0;
        next_cycle();
        mem_req_ready = 0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid = 1; mem_resp_data = rnd_data();
            @(negedge clk);
            chk_cnt++;
            if ({ic_resp_valid, dc_resp_valid} !== 2'b01)
                $display("FAIL rst_pre%0d: got ic/dc valid=%b want 01", b, {ic_resp_valid, dc_resp_valid});
            else pass_cnt++;
            next_cycle();
        end
        mem_resp_valid = 0;
        reset = 1;
        next_cycle();
        reset = 0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid = 1; mem_resp_data = rnd_data();
            @(negedge clk);
            chk_cnt++;
            if ({ic_req_ready, dc_req_ready, busy, mem_req_valid, mem_req_data_valid,
                 ic_resp_valid, dc_resp_valid, ic_wdata_ready, dc_wdata_ready} !== 9'b0)
                $display("FAIL rst_post%0d: got flags=%b want 000000000", b,
                         {ic_req_ready, dc_req_ready, busy, mem_req_valid, mem_req_data_valid,
                          ic_resp_valid, dc_resp_valid, ic_wdata_ready, dc_wdata_ready});
            else pass_cnt++;
            next_cycle();
        end
        mem_resp_valid = 0;
        dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h0000300;
        mem_req_ready = 1;
        @(negedge clk);
        chk_cnt++;
        if (dc_req_ready !== 1'b1) $display("FAIL rst_regrant: got dc_req_ready=%0b want 1", dc_req_ready);
        else pass_cnt++;
        next_cycle();
        dc_req_valid = 0;
        next_cycle();
        mem_req_ready = 0;
        for (int b = 0; b <= BEATS; b++) begin
            mem_resp_valid = (b < BEATS); mem_resp_data = rnd_data();
            @(negedge clk);
            chk_cnt++;
            if ({dc_resp_valid, busy} !== ((b < BEATS) ? 2'b11 : 2'b00))
                $display("FAIL rst_read%0d: got dcv/busy=%b want %b", b,
                         {dc_resp_valid, busy}, (b < BEATS) ? 2'b11 : 2'b00);
            else pass_cnt++;
            next_cycle();
        end
        drive_idle();
    endtask

    // Transaction-level model: grant by request pattern and last winner,
    // then a block of BEATS handshakes in order, routed to the winner only.
    task automatic test_random();
        bit            last_dc, exp_dc, e_rw, v, r;
        logic [AW-1:0] e_addr;
        logic [1:0]    pat;
        logic [DW-1:0] wd [BEATS];
        logic [MW-1:0] wm [BEATS];
        int            k, cyc, stall;
        reset = 1;
        next_cycle();
        reset = 0;
        last_dc = 0;
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) begin
                drive_idle();
                mem_resp_valid = 1'($urandom);
                @(negedge clk);
                chk_cnt++;
                if ({ic_resp_valid, dc_resp_valid, busy} !== 3'b000)
                    $display("FAIL rnd_idle%0d: got icv/dcv/busy=%b want 000", t,
                             {ic_resp_valid, dc_resp_valid, busy});
                else pass_cnt++;
                next_cycle();
            end
            drive_idle();
            pat = 2'($urandom_range(1, 3));
            ic_req_valid = pat[0]; ic_req_rw = 1'($urandom); ic_req_addr = AW'($urandom);
            dc_req_valid = pat[1]; dc_req_rw = 1'($urandom); dc_req_addr = AW'($urandom);
            exp_dc = (pat == 2'd2) || (pat == 2'd3 && !last_dc);
            e_rw   = exp_dc ? dc_req_rw : ic_req_rw;
            e_addr = exp_dc ? dc_req_addr : ic_req_addr;
            @(negedge clk);
            chk_cnt++;
            if ({ic_req_ready, dc_req_ready} !== {!exp_dc, exp_dc})
                $display("FAIL rnd_grant%0d: got ic/dc ready=%b want %b", t,
                         {ic_req_ready, dc_req_ready}, {!exp_dc, exp_dc});
            else pass_cnt++;
            last_dc = exp_dc;
            next_cycle();
            drive_idle();
            stall = $urandom_range(0, 3);
            for (int s = 0; s <= stall; s++) begin
                mem_req_ready = (s == stall);
                @(negedge clk);
                chk_cnt++;
                if ({mem_req_valid, mem_req_rw, mem_req_addr} !== {1'b1, e_rw, e_addr})
                    $display("FAIL rnd_cmd%0d: got v=%0b rw=%0b addr=%h want 1/%0b/%h", t,
                             mem_req_valid, mem_req_rw, mem_req_addr, e_rw, e_addr);
                else pass_cnt++;
                next_cycle();
            end
            mem_req_ready = 0;
            for (int i = 0; i < BEATS; i++) begin
                wd[i] = rnd_data();
                wm[i] = MW'($urandom);
            end
            k = 0; cyc = 0;
            while (k < BEATS && cyc < 64) begin
                v = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 2) != 0);
                if (e_rw) begin
                    ic_wdata_valid = exp_dc ? 1'($urandom) : v;
                    ic_wdata = exp_dc ? rnd_data() : wd[k];
                    ic_wmask = exp_dc ? MW'($urandom) : wm[k];
                    dc_wdata_valid = exp_dc ? v : 1'($urandom);
                    dc_wdata = exp_dc ? wd[k] : rnd_data();
                    dc_wmask = exp_dc ? wm[k] : MW'($urandom);
                    mem_req_data_ready = r;
                    mem_resp_valid = 1'($urandom);
                    @(negedge clk);
                    chk_cnt++;
                    if (mem_req_data_valid !== v ||
                        (v && {mem_req_data_bits, mem_req_data_mask} !== {wd[k], wm[k]}))
                        $display("FAIL rnd_wdata%0d_%0d: got v=%0b bits=%h mask=%h want %0b/%h/%h",
                                 t, k, mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
                                 v, wd[k], wm[k]);
                    else pass_cnt++;
                    chk_cnt++;
                    if ({ic_wdata_ready, dc_wdata_ready, ic_resp_valid, dc_resp_valid} !==
                        {!exp_dc && r, exp_dc && r, 2'b00})
                        $display("FAIL rnd_wctl%0d_%0d: got icwr/dcwr/icv/dcv=%b want %b", t, cyc,
                                 {ic_wdata_ready, dc_wdata_ready, ic_resp_valid, dc_resp_valid},
                                 {!exp_dc && r, exp_dc && r, 2'b00});
                    else pass_cnt++;
                    if (v && r) k++;
                end else begin
                    mem_resp_valid = v; mem_resp_data = rnd_data();
                    mem_req_data_ready = r;
                    @(negedge clk);
                    chk_cnt++;
                    if ({ic_resp_valid, dc_resp_valid} !== {!exp_dc && v, exp_dc && v} ||
                        (v && (exp_dc ? dc_resp_data : ic_resp_data) !== mem_resp_data))
                        $display("FAIL rnd_resp%0d_%0d: got ic/dc valid=%b want %b", t, cyc,
                                 {ic_resp_valid, dc_resp_valid}, {!exp_dc && v, exp_dc && v});
                    else pass_cnt++;
                    if (v) k++;
                end
                cyc++;
                next_cycle();
            end
            drive_idle();
            @(negedge clk);
            chk_cnt++;
            if (k !== BEATS || busy !== 1'b0)
                $display("FAIL rnd_done%0d: got beats=%0d busy=%0b want %0d/0", t, k, busy, BEATS);
            else pass_cnt++;
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_stall();
        test_cmd_backpressure();
        test_stray_resp();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d passed", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
